// File: rtl/test_gate.sv
// test_gate: two-input logic cell with a registered copy, edge pulses and a saturating high-cycle counter
module test_gate #(
    parameter logic [2:0] FUNC  = 3'd0,
    parameter int         CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             cnt_clr,
    output logic             y,
    output logic             y_q,
    output logic             y_rise,
    output logic             y_fall,
    output logic [CNT_W-1:0] hi_count
);
    logic             y_rise_d;
    logic             y_fall_d;
    logic [CNT_W-1:0] hi_count_d;

    always_comb begin
        y = FUNC == 3'd0 ? a & b :
            FUNC == 3'd1 ? a | b :
            FUNC == 3'd2 ? a ^ b :
            FUNC == 3'd3 ? ~(a & b) :
            FUNC == 3'd4 ? ~(a | b) :
            FUNC == 3'd5 ? ~(a ^ b) :
            FUNC == 3'd6 ? a : b;
        y_rise_d   = y & ~y_q;
        y_fall_d   = ~y & y_q;
        hi_count_d = cnt_clr ? '0 :
                     (y && hi_count != '1) ? hi_count + CNT_W'(1) : hi_count;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q      <= 1'b0;
            y_rise   <= 1'b0;
            y_fall   <= 1'b0;
            hi_count <= '0;
        end else begin
            y_q      <= y;
            y_rise   <= y_rise_d;
            y_fall   <= y_fall_d;
            hi_count <= hi_count_d;
        end
    end
endmodule

// File: tb/tb_test_gate.sv
// tb_test_gate: all eight functions plus a 2-bit-counter instance, checked against a truth-table model
module tb_test_gate;
    logic       clk = 0, rst = 1, a = 0, b = 0, cnt_clr = 0, run = 0;
    logic [8:0] y_o, yq_o, rise_o, fall_o;
    logic [7:0] cnt_o [8];
    logic [1:0] cnt_s;
    int         n_cmp = 0, n_bad = 0;
    // Index {b,a}: bit0 is ab=00, bit1 ab=10, bit2 ab=01, bit3 ab=11
    logic [3:0] tt [8] = '{4'b1000, 4'b1110, 4'b0110, 4'b0111,
                           4'b0001, 4'b1001, 4'b1010, 4'b1100};
    bit         m_yq [9], m_r [9], m_f [9];
    int         m_cnt [9];

    always begin
        #5;
        if (run) clk = ~clk;
    end

    for (genvar f = 0; f < 8; f++) begin : g
        test_gate #(.FUNC(3'(f)), .CNT_W(8)) u (
            .clk(clk), .rst(rst), .a(a), .b(b), .cnt_clr(cnt_clr),
            .y(y_o[f]), .y_q(yq_o[f]), .y_rise(rise_o[f]), .y_fall(fall_o[f]),
            .hi_count(cnt_o[f])
        );
    end

    test_gate #(.FUNC(3'd0), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .a(a), .b(b), .cnt_clr(cnt_clr),
        .y(y_o[8]), .y_q(yq_o[8]), .y_rise(rise_o[8]), .y_fall(fall_o[8]),
        .hi_count(cnt_s)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit ey(input int f);
        logic [3:0] t;
        t = tt[f == 8 ? 0 : f];
        return t[{b, a}];
    endfunction

    function automatic logic [31:0] cnt_of(input int f);
        return f == 8 ? 32'(cnt_s) : 32'(cnt_o[f]);
    endfunction

    task automatic model_reset();
        for (int f = 0; f < 9; f++) begin
            m_yq[f] = 0; m_r[f] = 0; m_f[f] = 0; m_cnt[f] = 0;
        end
    endtask

    task automatic model_edge();
        bit e;
        int top;
        if (rst) return;
        for (int f = 0; f < 9; f++) begin
            e   = ey(f);
            top = f == 8 ? 3 : 255;
            m_r[f]  = e && !m_yq[f];
            m_f[f]  = !e && m_yq[f];
            m_yq[f] = e;
            m_cnt[f] = cnt_clr ? 0 : (e && m_cnt[f] < top) ? m_cnt[f] + 1 : m_cnt[f];
        end
    endtask

    task automatic check_all();
        for (int f = 0; f < 9; f++) begin
            chk($sformatf("y[%0d]", f), 32'(y_o[f]), 32'(ey(f)));
            chk($sformatf("y_q[%0d]", f), 32'(yq_o[f]), 32'(m_yq[f]));
            chk($sformatf("y_rise[%0d]", f), 32'(rise_o[f]), 32'(m_r[f]));
            chk($sformatf("y_fall[%0d]", f), 32'(fall_o[f]), 32'(m_f[f]));
            chk($sformatf("hi_count[%0d]", f), cnt_of(f), 32'(m_cnt[f]));
        end
    endtask

    task automatic step(input bit na, input bit nb, input bit nc);
        a = na; b = nb; cnt_clr = nc;
        #1;
        for (int f = 0; f < 9; f++) chk($sformatf("y_pre[%0d]", f), 32'(y_o[f]), 32'(ey(f)));
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic async_reset();
        rst = 1;
        #1;
        model_reset();
        check_all();
    endtask

    initial begin
        int sat_exp [6] = '{1, 2, 3, 3, 3, 3};
        model_reset();
        for (int i = 0; i < 4; i++) begin
            a = i[0]; b = i[1];
            #10;
            for (int f = 0; f < 9; f++) chk($sformatf("comb[%0d] ab=%0d%0d", f, a, b), 32'(y_o[f]), 32'(ey(f)));
        end
        check_all();
        run = 1;
        @(posedge clk);
        #1;
        check_all();
        rst = 0;

        repeat (3) step(1, 1, 0);
        chk("reg_hi3", 32'(cnt_o[0]), 32'd3);
        chk("reg_yq", 32'(yq_o[0]), 32'd1);
        chk("reg_rise_once", 32'(rise_o[0]), 32'd0);
        step(1, 0, 0);
        chk("reg_fall", 32'(fall_o[0]), 32'd1);
        step(1, 0, 0);
        chk("reg_fall_end", 32'(fall_o[0]), 32'd0);

        async_reset();
        rst = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 0);
            chk($sformatf("sat_%0d", i), 32'(cnt_s), 32'(sat_exp[i]));
        end
        step(1, 1, 1);
        chk("sat_clr", 32'(cnt_s), 32'd0);

        async_reset();
        rst = 0;
        repeat (5) step(1, 1, 0);
        chk("mid_cnt5", 32'(cnt_o[0]), 32'd5);
        #3;
        async_reset();
        chk("mid_yq0", 32'(yq_o[0]), 32'd0);
        chk("mid_cnt0", 32'(cnt_o[0]), 32'd0);
        a = 0;
        #1;
        chk("mid_y_follow0", 32'(y_o[0]), 32'd0);
        a = 1;
        #1;
        chk("mid_y_follow1", 32'(y_o[0]), 32'd1);
        rst = 0;
        step(1, 1, 0);
        chk("rel_yq", 32'(yq_o[0]), 32'd1);
        chk("rel_cnt", 32'(cnt_o[0]), 32'd1);
        chk("rel_rise", 32'(rise_o[0]), 32'd1);

        repeat (300) begin
            if ($urandom_range(0, 31) == 0) begin
                #2;
                async_reset();
                rst = 0;
            end
            step(1'($urandom), 1'($urandom), $urandom_range(0, 15) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
